// File: rtl/tick_serializer.sv
// ============================================================================
// Module   : tick_serializer
// Desc     : Tick-paced serializer; sends start bit, data LSB first, stop bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_serializer #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int               IDX_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [1:0]       C_STOP_LAST = 2'(STOP_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [IDX_W-1:0]  w_bit_idx_nxt;
    logic [1:0]        r_stop_cnt;
    logic [1:0]        w_stop_cnt_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_accept;
    logic [DATA_W-1:0] w_shift_rs;

    assign w_accept   = valid && (r_state == S_IDLE);
    assign w_shift_rs = r_shift >> 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // A tick arriving in the accept cycle is deliberately not consumed:
    // IDLE only looks at the handshake, so the start bit waits for the next tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = data_in;
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tick) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    w_tx_nxt      = r_shift[0];
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (r_bit_idx < C_LAST_IDX) begin
                        w_shift_nxt   = w_shift_rs;
                        w_tx_nxt      = w_shift_rs[0];
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end else begin
                        w_tx_nxt       = 1'b1;
                        w_stop_cnt_nxt = 2'd1;
                        w_state_nxt    = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (r_stop_cnt < C_STOP_LAST) begin
                        w_stop_cnt_nxt = r_stop_cnt + 2'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign ready      = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tx         = r_tx;
    assign frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tick_serializer.sv
// ============================================================================
// Module   : tb_tick_serializer
// Desc     : Scoreboard bench for two tick_serializer configurations (8N1, 5N2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_serializer;

    localparam int DW_A = 8;
    localparam int SB_A = 1;
    localparam int DW_B = 5;
    localparam int SB_B = 2;

    localparam int T_OFF   = 0;
    localparam int T_PER   = 1;
    localparam int T_IRREG = 2;
    localparam int T_RAND  = 3;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic [1:0] valid_v;
    logic [7:0] data_a;
    logic [7:0] data_b;
    wire  [1:0] tx_w;
    wire  [1:0] rdy_w;
    wire  [1:0] busy_w;
    wire  [1:0] done_w;

    int tmode = T_OFF;
    int errors = 0;
    int checks = 0;

    tick_serializer #(.DATA_W(DW_A), .STOP_BITS(SB_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .tick(tick), .data_in(data_a),
        .valid(valid_v[0]), .ready(rdy_w[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .frame_done(done_w[0])
    );

    tick_serializer #(.DATA_W(DW_B), .STOP_BITS(SB_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .tick(tick), .data_in(data_b[4:0]),
        .valid(valid_v[1]), .ready(rdy_w[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .frame_done(done_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tick source: periodic every 5 cycles, an irregular gap pattern, or random.
    int pcnt = 0;
    int lowleft = 0;
    int pidx = 0;
    int pat[4] = '{0, 6, 2, 3};

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            case (tmode)
                T_PER: begin
                    tick = (pcnt == 0);
                    pcnt = (pcnt == 4) ? 0 : pcnt + 1;
                end
                T_IRREG: begin
                    if (lowleft == 0) begin
                        tick    = 1'b1;
                        lowleft = pat[pidx];
                        pidx    = (pidx + 1) % 4;
                    end else begin
                        tick    = 1'b0;
                        lowleft = lowleft - 1;
                    end
                end
                T_RAND:  tick = ($urandom_range(0, 2) == 0);
                default: tick = 1'b0;
            endcase
        end
    end

    // Scoreboard: drivers append accepted words, the monitor consumes via read index.
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    task automatic push(input int i, input logic [7:0] w);
        if (i == 0) q_a.push_back(w);
        else        q_b.push_back(w);
    endtask

    task automatic set_data(input int i, input logic [7:0] w);
        if (i == 0) data_a = w;
        else        data_b = w;
    endtask

    // Reference model: a frame is a list of line levels indexed by tick count
    // since accept; tick 1 is the start bit, then data, then stop bits, and the
    // tick after the last stop period ends the frame.
    bit         m_active[2];
    int         m_k[2];
    logic [7:0] m_word[2];
    logic       m_tx[2];
    logic       m_done[2];
    int         rd[2];
    logic       c_tick;
    logic [1:0] c_valid;
    logic       c_rst;

    task automatic model_step(input int i);
        int  dw = (i == 0) ? DW_A : DW_B;
        int  sb = (i == 0) ? SB_A : SB_B;
        bit  avail;
        if (!c_rst || !reset_n) begin
            m_active[i] = 1'b0;
            m_k[i]      = 0;
            m_tx[i]     = 1'b1;
            m_done[i]   = 1'b0;
            rd[i]       = (i == 0) ? q_a.size() : q_b.size();
        end else begin
            m_done[i] = 1'b0;
            if (!m_active[i]) begin
                if (c_valid[i]) begin
                    avail = (i == 0) ? (q_a.size() > rd[0]) : (q_b.size() > rd[1]);
                    chk($sformatf("scoreboard_word_ready[%0d]", i), avail, 1);
                    if (avail) begin
                        m_word[i]   = (i == 0) ? q_a[rd[0]] : q_b[rd[1]];
                        rd[i]       = rd[i] + 1;
                        m_active[i] = 1'b1;
                        m_k[i]      = 0;
                    end
                end
            end else if (c_tick) begin
                m_k[i] = m_k[i] + 1;
                if (m_k[i] == 1)                m_tx[i] = 1'b0;
                else if (m_k[i] <= dw + 1)      m_tx[i] = m_word[i][m_k[i] - 2];
                else if (m_k[i] <= dw + 1 + sb) m_tx[i] = 1'b1;
                else begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b1;
                    m_tx[i]     = 1'b1;
                end
            end
        end
        chk($sformatf("tx[%0d]", i),         tx_w[i],   m_tx[i]);
        chk($sformatf("ready[%0d]", i),      rdy_w[i],  !m_active[i]);
        chk($sformatf("busy[%0d]", i),       busy_w[i], m_active[i]);
        chk($sformatf("frame_done[%0d]", i), done_w[i], m_done[i]);
    endtask

    initial begin
        c_rst = 1'b0;
        forever begin
            @(posedge clk);
            c_tick  = tick;
            c_valid = valid_v;
            c_rst   = reset_n;
            @(negedge clk);
            model_step(0);
            model_step(1);
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input int i, input logic [7:0] w, input bit keep);
        int n   = 0;
        bit acc = 1'b0;
        valid_v[i] = 1'b1;
        set_data(i, w);
        while (!acc && n < 4000) begin
            acc = rdy_w[i];
            if (acc) push(i, w);
            @(negedge clk);
            n++;
        end
        chk($sformatf("send_accepted[%0d]", i), acc, 1);
        if (!keep) begin
            valid_v[i] = 1'b0;
            set_data(i, 8'($urandom));
        end
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy_w[i] !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_reached[%0d]", i), busy_w[i], 0);
    endtask

    task automatic measure(input int i, input int exp_cycles);
        int n = 0;
        while (tx_w[i] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("start_bit_seen[%0d]", i), tx_w[i], 0);
        n = 0;
        while (done_w[i] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("start_to_done_cycles[%0d]", i), n, exp_cycles);
    endtask

    task automatic chk_idle(input string name);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_tx[%0d]", name, i),    tx_w[i],   1);
            chk($sformatf("%s_ready[%0d]", name, i), rdy_w[i],  1);
            chk($sformatf("%s_busy[%0d]", name, i),  busy_w[i], 0);
            chk($sformatf("%s_done[%0d]", name, i),  done_w[i], 0);
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        valid_v = 2'b00;
        data_a  = 8'h00;
        data_b  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle("after_release");

        // Basic frames on both configurations with a 5-cycle tick.
        tmode = T_PER;
        send(0, 8'hA5, 1'b0);
        measure(0, 50);
        send(1, 8'h1F, 1'b0);
        measure(1, 40);
        wait_idle(0);
        wait_idle(1);

        // valid held across two words.
        send(0, 8'h3C, 1'b1);
        send(0, 8'hC3, 1'b0);
        wait_idle(0);

        // Accept lands on a tick edge; that tick must not start the frame.
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!tick && n < 100);
        chk("tick_observed", tick, 1);
        repeat (5) @(negedge clk);
        send(0, 8'h01, 1'b0);
        chk("coincident_tx_hold", tx_w[0], 1);
        repeat (4) @(negedge clk);
        chk("coincident_tx_hold_late", tx_w[0], 1);
        @(negedge clk);
        chk("coincident_start_bit", tx_w[0], 0);
        wait_idle(0);

        // Irregular gaps including back-to-back tick cycles.
        tmode = T_IRREG;
        fork
            begin
                for (int j = 0; j < 3; j++) send(0, 8'($urandom), 1'b0);
            end
            begin
                for (int j = 0; j < 3; j++) send(1, 8'($urandom), 1'b0);
            end
        join
        wait_idle(0);
        wait_idle(1);

        // Random ticks, random words, random gaps and held-valid streams.
        tmode = T_RAND;
        fork
            begin
                for (int j = 0; j < 40; j++) begin
                    bit kp = (j != 39) && ($urandom_range(0, 3) == 0);
                    send(0, 8'($urandom), kp);
                    if (!kp) repeat ($urandom_range(0, 8)) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    bit kp = (j != 39) && ($urandom_range(0, 3) == 0);
                    send(1, 8'($urandom), kp);
                    if (!kp) repeat ($urandom_range(0, 8)) @(negedge clk);
                end
            end
        join
        wait_idle(0);
        wait_idle(1);

        // Asynchronous reset in the middle of a frame.
        tmode = T_PER;
        send(0, 8'($urandom), 1'b0);
        send(1, 8'($urandom), 1'b0);
        repeat (17) @(negedge clk);
        chk("midframe_busy[0]", busy_w[0], 1);
        chk("midframe_busy[1]", busy_w[1], 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, 8'h5A, 1'b0);
        send(1, 8'h0B, 1'b0);
        wait_idle(0);
        wait_idle(1);

        tmode = T_OFF;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
